restoring_divider_8bit: RTL and testbench
=========================================

RESTORING_DIVIDER_8BIT -- requirements
Module: restoring_divider_8bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  request a division; accepted only in IDLE.
REQ-005 A  input  8  unsigned dividend; sampled on the accepting edge only.
REQ-006 B  input  8  unsigned divisor; sampled on the accepting edge only.
REQ-007 busy  output  1  high in CALC and DONE states.
REQ-008 done  output  1  one-cycle pulse; Q, R and div_by_zero are valid while it is high.
REQ-009 Q  output  8  quotient, registered.
REQ-010 R  output  8  remainder, registered.
REQ-011 div_by_zero  output  1  set with done when the latched B was 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 Transitions SHALL be:
  - IDLE to CALC: start=1 and B!=0.
  - IDLE to DONE: start=1 and B==0.
  - CALC to DONE: after the 8th iteration.
  - DONE to IDLE: always.
REQ-014 On the accepting edge T, the block SHALL latch A and B, clear the 9-bit partial remainder, clear the 3-bit iteration counter, and clear div_by_zero.
REQ-015 Each CALC edge SHALL perform one restoring step, MSB first:
  - Shift the dividend MSB into the partial remainder.
  - Form trial = partial - {1'b0,B} at 9-bit width.
  - If trial is non-negative: take trial as the new partial and shift in a quotient bit of 1.
  - Otherwise: keep the partial and shift in 0.
REQ-016 The iteration counter SHALL increment once per CALC edge; CALC SHALL end on the edge where the counter wraps from 7.
REQ-017 For B!=0, exactly 8 iterations SHALL run on edges T+1..T+8, with Q and R loaded at edge T+8 and done high for the cycle following edge T+8.
REQ-018 For B==0, the block SHALL at edge T+1 load Q=8'hFF, R=A and div_by_zero=1, and assert done for one cycle.
REQ-019 Results SHALL satisfy A == Q*B + R and R < B for every B!=0.
REQ-020 Q, R and div_by_zero SHALL hold their last values until the next done or reset.
REQ-021 A start asserted in CALC or DONE SHALL be ignored, not queued.
REQ-022 Changes on A or B after the accepting edge SHALL NOT affect the result in progress.
REQ-023 done SHALL never be high for two consecutive cycles.
REQ-024 busy SHALL be low in the cycle after done.
REQ-025 A start in the cycle after done SHALL be accepted normally; back-to-back throughput SHALL be one result per 10 cycles.

Reset
REQ-026 reset_n=0 at a rising edge SHALL force:
  - state to IDLE;
  - busy=0, done=0, Q=0, R=0, div_by_zero=0;
  - iteration counter and partial remainder to 0.
REQ-027 Reset SHALL take priority over start and over any FSM transition.
REQ-028 Reset during CALC or DONE SHALL abort the operation with no done pulse.
REQ-029 After reset is released, the next start SHALL behave as a fresh first operation.

Verification
REQ-030 A=100, B=7, start pulse at edge T -> done high after edge T+8; Q=14, R=2, div_by_zero=0; busy high for edges T..T+8.
REQ-031 A=255, B=1 -> Q=255, R=0; then A=5, B=9 -> Q=0, R=5; both issued back-to-back (start in the cycle after done) with 10-cycle spacing.
REQ-032 A=200, B=0 -> done after edge T+1; Q=8'hFF, R=200, div_by_zero=1; a following A=9, B=3 -> Q=3, R=0, div_by_zero=0.
REQ-033 A=100, B=7 started; start re-pulsed with A=50, B=5 during CALC and during DONE -> both ignored; result Q=14, R=2; a single done pulse.
REQ-034 reset_n=0 for one cycle at edge T+4 of an active division -> all outputs 0, no done pulse; a subsequent A=17, B=4 -> Q=4, R=1.
REQ-035 Random sweep of all 65536 (A,B) pairs against a reference model -> every result matches REQ-018/REQ-019, and done spacing matches REQ-017.

Source files
------------

// File: rtl/restoring_divider_8bit_if.sv
// Handshake and result bus between a division requester and the 8-bit restoring divider.
interface restoring_divider_8bit_if;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] Q;
    logic [7:0] R;
    logic       div_by_zero;

    // Requester side: issues operands, observes status and results.
    modport master (
        output start, A, B,
        input  busy, done, Q, R, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, A, B,
        output busy, done, Q, R, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_8bit.sv
// 8-bit unsigned restoring divider: one quotient bit per cycle, MSB first.
// A request accepted in idle takes 8 compute cycles plus one done cycle; divide-by-zero
// short-circuits to Q=FF, R=A with div_by_zero set.
module restoring_divider_8bit (
    input  logic                           clk,
    input  logic                           reset_n,
    restoring_divider_8bit_if.slave        div_if
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e     state_q;
    logic [7:0] a_q;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [7:0] b_q;
    logic [8:0] part_q;   // partial remainder
    logic [2:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] q_q;
    logic [7:0] r_q;
    logic       dbz_q;

    logic [8:0] shifted;
    logic [8:0] trial;
    logic [8:0] part_d;
    logic [7:0] a_d;

    // The partial remainder is always below B, so its MSB never reaches the shift.
    logic unused_part_msb;
    assign unused_part_msb = part_q[8];

    // One restoring step: shift in the next dividend bit and try subtracting the divisor.
    always_comb begin
        shifted = {part_q[7:0], a_q[7]};
        trial   = shifted - {1'b0, b_q};
        part_d  = shifted;
        a_d     = {a_q[6:0], 1'b0};
        if (!trial[8]) begin
            part_d = trial;
            a_d    = {a_q[6:0], 1'b1};
        end
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            part_q  <= 9'd0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= 8'd0;
            r_q     <= 8'd0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (div_if.start) begin
                        a_q     <= div_if.A;
                        b_q     <= div_if.B;
                        part_q  <= 9'd0;
                        cnt_q   <= 3'd0;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (div_if.B == 8'd0) ? StDone : StCalc;
                    end
                end
                StCalc: begin
                    a_q    <= a_d;
                    part_q <= part_d;
                    cnt_q  <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= StDone;
                        q_q     <= a_d;
                        r_q     <= part_d[7:0];
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    // A zero divisor only reaches here straight from idle; results land now.
                    if (b_q == 8'd0) begin
                        q_q    <= 8'hFF;
                        r_q    <= a_q;
                        dbz_q  <= 1'b1;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign div_if.busy        = busy_q;
    assign div_if.done        = done_q;
    assign div_if.Q           = q_q;
    assign div_if.R           = r_q;
    assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Directed bench for restoring_divider_8bit: latency, results, ignored starts, reset abort.
module tb_restoring_divider_8bit;

    logic clk;
    logic reset_n;
    int   nchecks;
    int   nerr;

    restoring_divider_8bit_if dif ();

    restoring_divider_8bit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div_if  (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one division, scramble the operands after acceptance, wait for done (bounded),
    // check latency and results, then step once more so a following call starts in the
    // cycle after done.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                           input int elat);
        int lat;
        dif.A     = a;
        dif.B     = b;
        dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        dif.A     = ~a;
        dif.B     = ~b;
        check({tag, " busy_after_accept"}, 16'(dif.busy), 16'd1);
        lat = 0;
        while (dif.done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 16'(lat), 16'(elat));
        check({tag, " Q"}, 16'(dif.Q), 16'(eq));
        check({tag, " R"}, 16'(dif.R), 16'(er));
        check({tag, " dbz"}, 16'(dif.div_by_zero), 16'(edbz));
        step();
        check({tag, " done_drops"}, 16'(dif.done), 16'd0);
        check({tag, " busy_after_done"}, 16'(dif.busy), 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat;
        int         cnt;
        logic [7:0] ra;
        logic [7:0] rb;

        nchecks   = 0;
        nerr      = 0;
        reset_n   = 1'b0;
        dif.start = 1'b0;
        dif.A     = 8'd0;
        dif.B     = 8'd0;
        step();
        step();
        check("reset busy", 16'(dif.busy), 16'd0);
        check("reset done", 16'(dif.done), 16'd0);
        check("reset Q", 16'(dif.Q), 16'd0);
        check("reset R", 16'(dif.R), 16'd0);
        check("reset dbz", 16'(dif.div_by_zero), 16'd0);
        reset_n = 1'b1;
        step();

        // 100 / 7: busy through T+8, done only after T+8.
        dif.A     = 8'd100;
        dif.B     = 8'd7;
        dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (dif.done !== 1'b0 || dif.busy !== 1'b1) cnt++;
        end
        check("100/7 early_done_or_idle", 16'(cnt), 16'd0);
        step();
        check("100/7 done", 16'(dif.done), 16'd1);
        check("100/7 busy_in_done", 16'(dif.busy), 16'd1);
        check("100/7 Q", 16'(dif.Q), 16'd14);
        check("100/7 R", 16'(dif.R), 16'd2);
        check("100/7 dbz", 16'(dif.div_by_zero), 16'd0);
        step();
        check("100/7 done_drops", 16'(dif.done), 16'd0);
        check("100/7 busy_drops", 16'(dif.busy), 16'd0);
        check("100/7 Q_holds", 16'(dif.Q), 16'd14);

        // Back-to-back requests, each started in the cycle after the previous done.
        run_div("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
        run_div("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
        run_div("200/0", 8'd200, 8'd0, 8'hFF, 8'd200, 1'b1, 1);
        run_div("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 8);
        run_div("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);
        run_div("254/255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 8);
        run_div("0/5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 8);
        run_div("128/2", 8'd128, 8'd2, 8'd64, 8'd0, 1'b0, 8);
        run_div("0/0", 8'd0, 8'd0, 8'hFF, 8'd0, 1'b1, 1);

        // Starts during CALC and DONE are ignored and not queued.
        dif.A     = 8'd100;
        dif.B     = 8'd7;
        dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        step();
        step();
        dif.A     = 8'd50;
        dif.B     = 8'd5;
        dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        lat = 3;
        while (dif.done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("ignore latency", 16'(lat), 16'd8);
        check("ignore Q", 16'(dif.Q), 16'd14);
        check("ignore R", 16'(dif.R), 16'd2);
        dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (dif.done !== 1'b0 || dif.busy !== 1'b0) cnt++;
            step();
        end
        check("ignore no_queued_op", 16'(cnt), 16'd0);
        check("ignore Q_holds", 16'(dif.Q), 16'd14);

        // Reset at T+4 aborts with no done pulse.
        dif.A     = 8'd100;
        dif.B     = 8'd7;
        dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        step();
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("abort busy", 16'(dif.busy), 16'd0);
        check("abort done", 16'(dif.done), 16'd0);
        check("abort Q", 16'(dif.Q), 16'd0);
        check("abort R", 16'(dif.R), 16'd0);
        check("abort dbz", 16'(dif.div_by_zero), 16'd0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (dif.done !== 1'b0 || dif.busy !== 1'b0) cnt++;
        end
        check("abort no_done", 16'(cnt), 16'd0);
        run_div("17/4", 8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 8);

        // Random pairs against the arithmetic definition.
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i % 16 == 0) rb = 8'd0;
            if (rb == 8'd0)
                run_div("rand", ra, rb, 8'hFF, ra, 1'b1, 1);
            else
                run_div("rand", ra, rb, ra / rb, ra % rb, 1'b0, 8);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
